// File: rtl/uart_link_pkg.sv
// Shared types and ASCII constants for the UART command-line decoder.
package uart_link_pkg;

    typedef enum logic [2:0] {
        S_TAG,
        S_COLON,
        S_SPACE,
        S_ZERO,
        S_X,
        S_HEX,
        S_DISCARD
    } state_e;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_X_LO  = 8'h78;
    localparam logic [7:0] CH_X_UP  = 8'h58;

    // Characters arrive zero-extended so any DATA_WIDTH can share these helpers.
    function automatic logic is_terminator(input logic [31:0] c);
        return (c == 32'(CH_CR)) || (c == 32'(CH_LF));
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit nibble.
module ascii_hex_decode #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_char,
    output logic [3:0]            o_nibble,
    output logic                  o_is_hex
);

    logic [31:0] w_c;
    assign w_c = 32'(i_char);

    always_comb begin
        o_nibble = '0;
        o_is_hex = 1'b0;
        if (w_c >= 32'h30 && w_c <= 32'h39) begin
            o_nibble = 4'(w_c - 32'h30);
            o_is_hex = 1'b1;
        end else if (w_c >= 32'h41 && w_c <= 32'h46) begin
            o_nibble = 4'(w_c - 32'h37);
            o_is_hex = 1'b1;
        end else if (w_c >= 32'h61 && w_c <= 32'h66) begin
            o_nibble = 4'(w_c - 32'h57);
            o_is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Streaming parser for "<TAG>: 0x<hex>" lines ending in CR/LF; commits values per channel.
module uart_cmd_decoder
    import uart_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned TAG_LEN      = 2,
    parameter logic [NUM_CHANNELS*TAG_LEN*DATA_WIDTH-1:0] CHANNEL_TAGS = 32'h4254_5357,
    parameter int unsigned HEX_DIGITS   = 4,
    parameter int unsigned VALUE_WIDTH  = 4 * HEX_DIGITS
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                ena,
    input  logic [DATA_WIDTH-1:0]               rx_data,
    input  logic                                rx_valid,
    output logic [NUM_CHANNELS*VALUE_WIDTH-1:0] value_out,
    output logic [NUM_CHANNELS-1:0]             update_strobe,
    output logic                                frame_error,
    output logic [7:0]                          error_count,
    output logic                                busy
);

    localparam int unsigned PosW = (TAG_LEN > 1) ? $clog2(TAG_LEN) : 1;
    localparam int unsigned ChW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned DigW = $clog2(HEX_DIGITS + 1);

    state_e                            r_state, w_state_d;
    logic [PosW-1:0]                   r_pos, w_pos_d;
    logic [NUM_CHANNELS-1:0]           r_cand, w_cand_d, w_match, w_cand_hit;
    logic [ChW-1:0]                    r_sel, w_sel_d, w_lowest;
    logic [VALUE_WIDTH-1:0]            r_acc, w_acc_d;
    logic [DigW-1:0]                   r_digits, w_digits_d;
    logic [NUM_CHANNELS*VALUE_WIDTH-1:0] r_value;
    logic [NUM_CHANNELS-1:0]           r_strobe;
    logic                              r_ferr;
    logic [7:0]                        r_err_cnt;
    logic                              w_accept, w_term, w_commit, w_error, w_is_hex, w_lit_ok;
    logic [3:0]                        w_nibble;
    logic [31:0]                       w_char;
    state_e                            w_lit_next;

    assign w_char   = 32'(rx_data);
    assign w_accept = ena && rx_valid;
    assign w_term   = is_terminator(w_char);

    ascii_hex_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hex (
        .i_char   (rx_data),
        .o_nibble (w_nibble),
        .o_is_hex (w_is_hex)
    );

    // Channel 0 sits in the most-significant tag slot; first character is its top byte.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_match[c] = (CHANNEL_TAGS[((NUM_CHANNELS - 1 - c) * TAG_LEN + TAG_LEN - 1
                          - 32'(r_pos)) * DATA_WIDTH +: DATA_WIDTH] == rx_data);
        end
    end

    assign w_cand_hit = r_cand & w_match;

    always_comb begin
        w_lowest = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (w_cand_hit[c]) w_lowest = ChW'(c);
        end
    end

    always_comb begin
        w_lit_ok   = 1'b0;
        w_lit_next = S_DISCARD;
        unique case (r_state)
            S_COLON: begin w_lit_ok = (w_char == 32'(CH_COLON)); w_lit_next = S_SPACE; end
            S_SPACE: begin w_lit_ok = (w_char == 32'(CH_SPACE)); w_lit_next = S_ZERO;  end
            S_ZERO:  begin w_lit_ok = (w_char == 32'(CH_ZERO));  w_lit_next = S_X;     end
            S_X: begin
                w_lit_ok   = (w_char == 32'(CH_X_LO)) || (w_char == 32'(CH_X_UP));
                w_lit_next = S_HEX;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d  = r_state;
        w_pos_d    = r_pos;
        w_cand_d   = r_cand;
        w_sel_d    = r_sel;
        w_acc_d    = r_acc;
        w_digits_d = r_digits;
        w_commit   = 1'b0;
        w_error    = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                S_TAG: begin
                    if (w_term) begin
                        w_error = (r_pos != '0);
                    end else if (w_cand_hit == '0) begin
                        w_state_d = S_DISCARD;
                        w_pos_d   = '0;
                    end else if (32'(r_pos) == TAG_LEN - 1) begin
                        w_cand_d  = w_cand_hit;
                        w_sel_d   = w_lowest;
                        w_pos_d   = '0;
                        w_state_d = S_COLON;
                    end else begin
                        w_cand_d = w_cand_hit;
                        w_pos_d  = r_pos + PosW'(1);
                    end
                end
                S_COLON, S_SPACE, S_ZERO, S_X: begin
                    if (w_lit_ok)    w_state_d = w_lit_next;
                    else if (w_term) w_error   = 1'b1;
                    else             w_state_d = S_DISCARD;
                end
                S_HEX: begin
                    if (w_term) begin
                        if (r_digits != '0) w_commit = 1'b1;
                        else                w_error  = 1'b1;
                    end else if (w_is_hex && (32'(r_digits) < HEX_DIGITS)) begin
                        w_acc_d    = (r_acc << 4) | VALUE_WIDTH'(w_nibble);
                        w_digits_d = r_digits + DigW'(1);
                    end else begin
                        w_state_d = S_DISCARD;
                    end
                end
                S_DISCARD: w_error = w_term;
                default:   w_state_d = S_TAG;
            endcase
            if (w_commit || w_error) begin
                w_state_d  = S_TAG;
                w_pos_d    = '0;
                w_cand_d   = '1;
                w_acc_d    = '0;
                w_digits_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_TAG;
            r_pos     <= '0;
            r_cand    <= '1;
            r_sel     <= '0;
            r_acc     <= '0;
            r_digits  <= '0;
            r_value   <= '0;
            r_strobe  <= '0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state  <= w_state_d;
            r_pos    <= w_pos_d;
            r_cand   <= w_cand_d;
            r_sel    <= w_sel_d;
            r_acc    <= w_acc_d;
            r_digits <= w_digits_d;
            r_strobe <= w_commit ? (NUM_CHANNELS'(1) << r_sel) : '0;
            r_ferr   <= w_error;
            if (w_commit) r_value[32'(r_sel) * VALUE_WIDTH +: VALUE_WIDTH] <= r_acc;
            if (w_error && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign value_out     = r_value;
    assign update_strobe = r_strobe;
    assign frame_error   = r_ferr;
    assign error_count   = r_err_cnt;
    assign busy          = (r_state != S_TAG) || (r_pos != '0);

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Streaming successor to the fixed 10-character window checker. It consumes received UART bytes one at a time through a valid strobe and parses lines of the form `<TAG>: 0x<hex>` terminated by CR or LF. The tags, tag count, tag length and hex digit count are parameters. On a good line it commits the value into that channel's output register and pulses a per-channel update strobe. Malformed lines are discarded and counted. It sits between the UART RX byte output and the switch/button mirror logic.

Parameters:
DATA_WIDTH, 8, character width in bits.
NUM_CHANNELS, 2, number of tags/value registers.
TAG_LEN, 2, characters per tag.
CHANNEL_TAGS, {"BT","SW"}, packed NUM_CHANNELS*TAG_LEN*DATA_WIDTH tag table; channel 0 occupies the most-significant TAG_LEN characters; the first character of each tag is its most-significant byte.
HEX_DIGITS, 4, maximum hex digits accepted per line.
VALUE_WIDTH, 4*HEX_DIGITS, width of each channel value (derived; do not override).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
ena  input  1  block enable; when low, rx_valid is ignored and all state holds.
rx_data  input  DATA_WIDTH  received character.
rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
value_out  output  NUM_CHANNELS*VALUE_WIDTH  committed values; channel i occupies bits [i*VALUE_WIDTH +: VALUE_WIDTH].
update_strobe  output  NUM_CHANNELS  one-cycle pulse on the channel whose value was just committed.
frame_error  output  1  one-cycle pulse when a malformed line ends.
error_count  output  8  saturating count of malformed lines.
busy  output  1  high when the FSM is not in S_TAG or the tag position is nonzero.

Behaviour:
- Reset (async, active-low):
  - value_out, update_strobe, frame_error and error_count clear to 0.
  - FSM goes to S_TAG with tag position 0 and every channel marked as a candidate.
- Bytes are accepted only on cycles where ena && rx_valid. No backpressure exists; every accepted byte is consumed in the cycle it arrives.
- A terminator is CR (0x0D) or LF (0x0A).
- FSM states: S_TAG, S_COLON, S_SPACE, S_ZERO, S_X, S_HEX, S_DISCARD.
- S_TAG:
  - Keep a NUM_CHANNELS-bit candidate mask. Each byte clears any candidate whose tag character at the current position differs.
  - After TAG_LEN matching bytes, select the lowest-index remaining candidate and go to S_COLON.
  - Mask becomes empty -> S_DISCARD.
  - A terminator arriving at position 0 is ignored (blank line, no error).
  - A terminator arriving at position >0 -> error.
- S_COLON expects ":", S_SPACE expects " ", S_ZERO expects "0", S_X accepts "x" or "X". A correct byte advances to the next state.
- S_HEX:
  - Digits 0-9, A-F and a-f are accepted. The accumulator shifts left 4 bits and ORs in the digit's nibble; a digit counter increments.
  - Fewer than HEX_DIGITS digits zero-extends, so "0x1F" gives 0x001F.
  - Terminator with digit count between 1 and HEX_DIGITS -> commit.
  - Terminator with 0 digits -> error.
  - A (HEX_DIGITS+1)th digit or any other character -> S_DISCARD.
- Wrong character in any parse state:
  - If it is a terminator -> error immediately.
  - Otherwise -> S_DISCARD.
- S_DISCARD swallows bytes until a terminator, then -> error.
- Commit: on the accepting edge, the selected channel's value_out slice loads the accumulator and its update_strobe bit goes high for exactly one cycle. Other channels are unchanged. The FSM returns to S_TAG.
- Error: frame_error pulses for one cycle and error_count increments, saturating at 255. The FSM returns to S_TAG with all candidates set and the accumulator cleared.
- Latency: value and strobe are visible in the cycle after the terminator is accepted.
- ena low mid-line: the partial parse is retained and resumes when ena returns high. Strobes still deassert the cycle after they were asserted.
- Reset mid-line: the partial line is lost and value_out clears.
- Duplicate tags in CHANNEL_TAGS: the lowest index always wins.

Decomposition:
- Package uart_link_pkg:
  - state enum.
  - ASCII constants for CR, LF, ':', ' ', '0', 'x'.
  - is_terminator() function.
- Sub-module ascii_hex_decode: combinational; DATA_WIDTH char in -> 4-bit nibble plus is_hex flag.

Test Plan:
- "SW: 0xBEEF\n" -> after the LF edge, channel1 = 0xBEEF, update_strobe = 2'b10 for 1 cycle, channel0 unchanged, error_count 0.
- "BT: 0x1f\r" -> channel0 = 0x001F, update_strobe = 2'b01; lowercase and short digit count both accepted.
- "SW: 0x12345\n" -> S_DISCARD on the 5th digit, channel1 unchanged, frame_error pulse, error_count 1. A following "SW: 0x0001\n" commits 0x0001.
- "XY: 0x0000\n", then "\n\n", then "SW: 0x\n" -> exactly 2 errors (the blank lines are ignored); all values unchanged.
- ena low for 20 cycles midway through "BT: 0x0A\n", with rx_valid pulses dropped during that time -> after resume the line completes with channel0 = 0x000A. Separately, asserting reset_n low mid-line asynchronously clears all outputs and the FSM.
- 300 malformed lines -> error_count saturates at 255.
